// File: rtl/mc_ctrl_if.sv
// Datapath control bundle between the multi-cycle main controller and the CPU datapath.
// master = controller side, slave = datapath side.
interface mc_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       Op;
    logic             MemReady;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             MemtoReg;
    logic             IRWrite;
    logic             RegWrite;
    logic             RegDst;
    logic             ALUSrcA;
    logic [1:0]       PCSource;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUop;
    logic [3:0]       State;
    logic             IllegalOp;
    logic [CNT_W-1:0] InstrCount;

    modport master (
        input  Op, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUop, State,
               IllegalOp, InstrCount
    );

    modport slave (
        output Op, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUop, State,
               IllegalOp, InstrCount
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main control FSM: fetch/decode/execute sequencing, datapath strobes,
// retired-instruction counter and sticky illegal-opcode flag.
//
// state   | meaning
// FETCH   | read instruction, PC+4 (waits on MemReady)
// DECODE  | register read, branch target in ALUOut
// MEM_ADR | effective address for lw/sw
// MEM_RD  | data memory read (waits on MemReady)
// MEM_WB  | load result written to rt
// MEM_WR  | data memory write (waits on MemReady), retires sw
// R_EXEC  | R-type ALU operation
// R_WB    | R-type result written to rd
// BRANCH  | beq compare, conditional PC update
// JUMP    | PC <- jump target
// I_EXEC  | addi ALU operation
// I_WB    | addi result written to rt
module mc_ctrl_fsm #(
    parameter int CNT_W = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    mc_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_R_EXEC  = 4'd6,
        S_R_WB    = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_I_EXEC  = 4'd10,
        S_I_WB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ill_q, ill_d;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg;
    logic       ir_write, reg_write, reg_dst, alu_src_a;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic       retire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ill_d         = ill_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        pc_source     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.MemReady;
                pc_write  = bus.MemReady;
                if (bus.MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (bus.Op)
                    OP_LW, OP_SW: state_d = S_MEM_ADR;
                    OP_R:         state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_I_EXEC;
                    default: begin
                        ill_d   = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (bus.Op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (bus.MemReady) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (bus.MemReady) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        cnt_d = retire ? (cnt_q + CNT_ONE) : cnt_q;

        // Held in reset: no strobes reach the datapath, selects park at their FETCH values.
        if (!rst_n) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            i_or_d        = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            alu_src_a     = 1'b0;
            pc_source     = 2'b00;
            alu_src_b     = 2'b01;
            alu_op        = 2'b00;
        end
    end

    assign bus.PCWrite     = pc_write;
    assign bus.PCWriteCond = pc_write_cond;
    assign bus.IorD        = i_or_d;
    assign bus.MemRead     = mem_read;
    assign bus.MemWrite    = mem_write;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.IRWrite     = ir_write;
    assign bus.RegWrite    = reg_write;
    assign bus.RegDst      = reg_dst;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.PCSource    = pc_source;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.ALUop       = alu_op;
    assign bus.State       = state_q;
    assign bus.IllegalOp   = ill_q;
    assign bus.InstrCount  = cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-cycle scoreboard of expected state/outputs,
// plus a CNT_W=4 instance for counter wrap.
module tb_mc_ctrl_fsm;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_n_w;

    always #5 clk = ~clk;

    mc_ctrl_if #(.CNT_W(16)) if_m ();
    mc_ctrl_if #(.CNT_W(4))  if_w ();

    mc_ctrl_fsm #(.CNT_W(16)) u_dut   (.clk(clk), .rst_n(rst_n),   .bus(if_m));
    mc_ctrl_fsm #(.CNT_W(4))  u_dut_w (.clk(clk), .rst_n(rst_n_w), .bus(if_w));

    typedef struct {
        bit mr;
        int st;
        bit ill;
        int cnt;
    } ent_t;

    ent_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   m_cnt = 0;
    bit   m_ill = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected strobe word from the state table:
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegWrite,RegDst,ALUSrcA,PCSource,ALUSrcB,ALUop}
    function automatic logic [15:0] exp_outs(input int st, input bit mr, input bit rstn);
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, sa;
        logic [1:0] psrc, sb_sel, aop;
        {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, sa} = '0;
        psrc = 2'b00; sb_sel = 2'b00; aop = 2'b00;
        if (!rstn) begin
            sb_sel = 2'b01;
        end else begin
            case (st)
                0:  begin mrd = 1; sb_sel = 2'b01; irw = mr; pcw = mr; end
                1:  sb_sel = 2'b11;
                2:  begin sa = 1; sb_sel = 2'b10; end
                3:  begin mrd = 1; iord = 1; end
                4:  begin rw = 1; m2r = 1; end
                5:  begin mwr = 1; iord = 1; end
                6:  begin sa = 1; aop = 2'b10; end
                7:  begin rw = 1; rdst = 1; end
                8:  begin sa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
                9:  begin pcw = 1; psrc = 2'b10; end
                10: begin sa = 1; sb_sel = 2'b10; end
                11: rw = 1;
                default: ;
            endcase
        end
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, sa, psrc, sb_sel, aop};
    endfunction

    function automatic logic [15:0] obs_outs();
        return {if_m.PCWrite, if_m.PCWriteCond, if_m.IorD, if_m.MemRead, if_m.MemWrite,
                if_m.MemtoReg, if_m.IRWrite, if_m.RegWrite, if_m.RegDst, if_m.ALUSrcA,
                if_m.PCSource, if_m.ALUSrcB, if_m.ALUop};
    endfunction

    task automatic push(input int st, input bit mr);
        ent_t e;
        e.st = st; e.mr = mr; e.ill = m_ill; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    function automatic bit rnd_mr();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected cycle-by-cycle trace of one instruction from its FETCH up to the next FETCH.
    task automatic push_instr(input logic [5:0] op, input int fstall, input int mstall);
        for (int i = 0; i < fstall; i++) push(0, 1'b0);
        push(0, 1'b1);
        push(1, rnd_mr());
        case (op)
            OP_R:    begin push(6, rnd_mr()); push(7, rnd_mr()); end
            OP_LW:   begin
                push(2, rnd_mr());
                for (int i = 0; i < mstall; i++) push(3, 1'b0);
                push(3, 1'b1);
                push(4, rnd_mr());
            end
            OP_SW:   begin
                push(2, rnd_mr());
                for (int i = 0; i < mstall; i++) push(5, 1'b0);
                push(5, 1'b1);
            end
            OP_BEQ:  push(8, rnd_mr());
            OP_J:    push(9, rnd_mr());
            OP_ADDI: begin push(10, rnd_mr()); push(11, rnd_mr()); end
            default: ;
        endcase
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: m_cnt = (m_cnt + 1) % 65536;
            default: m_ill = 1'b1;
        endcase
    endtask

    // Called at a negedge; each popped entry covers one clock cycle.
    task automatic run_queue(input string tag);
        ent_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if_m.MemReady = e.mr;
            #1;
            chk({tag, ".state"}, 32'(if_m.State), 32'(e.st));
            chk({tag, ".outs"},  32'(obs_outs()), 32'(exp_outs(e.st, e.mr, 1'b1)));
            chk({tag, ".ill"},   32'(if_m.IllegalOp), 32'(e.ill));
            chk({tag, ".cnt"},   32'(if_m.InstrCount), 32'(e.cnt));
            @(negedge clk);
        end
    endtask

    task automatic run_instr(input string tag, input logic [5:0] op, input int fstall, input int mstall);
        if_m.Op = op;
        push_instr(op, fstall, mstall);
        run_queue(tag);
    endtask

    initial begin
        rst_n         = 1'b0;
        rst_n_w       = 1'b0;
        if_m.Op       = OP_R;
        if_m.MemReady = 1'b1;
        if_w.Op       = OP_J;
        if_w.MemReady = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        chk("rst.state", 32'(if_m.State), 32'd0);
        chk("rst.outs",  32'(obs_outs()), 32'(exp_outs(0, 1'b1, 1'b0)));
        chk("rst.ill",   32'(if_m.IllegalOp), 32'd0);
        chk("rst.cnt",   32'(if_m.InstrCount), 32'd0);
        chk("rst_w.strobes", 32'({if_w.PCWrite, if_w.IRWrite, if_w.MemRead}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_instr("rtype", OP_R,    0, 0);
        run_instr("lw",    OP_LW,   0, 3);
        run_instr("beq",   OP_BEQ,  0, 0);
        run_instr("j",     OP_J,    0, 0);
        run_instr("ill",   OP_BAD,  0, 0);
        run_instr("addi",  OP_ADDI, 0, 0);
        run_instr("fstl",  OP_R,    2, 0);
        run_instr("sw",    OP_SW,   0, 2);

        // Abort a stalled store with a one-cycle reset.
        if_m.Op = OP_SW;
        push(0, 1'b1); push(1, rnd_mr()); push(2, rnd_mr()); push(5, 1'b0);
        run_queue("sw_abort");
        if_m.MemReady = 1'b0;
        #1;
        chk("abort.pre_state", 32'(if_m.State), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("abort.memwrite", 32'(if_m.MemWrite), 32'd0);
        chk("abort.outs", 32'(obs_outs()), 32'(exp_outs(5, 1'b0, 1'b0)));
        @(negedge clk);
        chk("abort.state", 32'(if_m.State), 32'd0);
        chk("abort.cnt",   32'(if_m.InstrCount), 32'd0);
        chk("abort.ill",   32'(if_m.IllegalOp), 32'd0);
        rst_n = 1'b1;
        m_cnt = 0;
        m_ill = 1'b0;
        run_instr("post", OP_R, 0, 0);
        #1;
        chk("post.cnt", 32'(if_m.InstrCount), 32'd1);

        // CNT_W=4 instance: 16 back-to-back jumps, 3 cycles each.
        rst_n_w = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            repeat (3) @(negedge clk);
            #1;
            chk($sformatf("wrap.state%0d", k), 32'(if_w.State), 32'd0);
            chk($sformatf("wrap.cnt%0d", k), 32'(if_w.InstrCount), 32'(k % 16));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
